// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: lane write, row read and status bundle for the psum output FIFO.
// o_overflow exists only when PSUM_OFIFO_OVF_EN is defined.
interface psum_ofifo_if #(
    parameter int col = 8,
    parameter int psum_bw = 16
);
    logic [col-1:0]         wr;
    logic [col*psum_bw-1:0] in;
    logic                   rd;
    logic [col*psum_bw-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
`ifdef PSUM_OFIFO_OVF_EN
    logic                   o_overflow;
`endif
    modport master (
        output wr, in, rd,
        input  out, o_valid, o_full, o_ready
`ifdef PSUM_OFIFO_OVF_EN
        , input o_overflow
`endif
    );
    modport slave (
        input  wr, in, rd,
        output out, o_valid, o_full, o_ready
`ifdef PSUM_OFIFO_OVF_EN
        , output o_overflow
`endif
    );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column FIFOs that realign skewed partial sums into whole rows.
// Define PSUM_OFIFO_OVF_EN to add the sticky o_overflow dropped-write flag.
module psum_ofifo #(
    parameter int col = 8,
    parameter int psum_bw = 16,
    parameter int depth = 64
) (
    input logic         clk,
    input logic         reset,
    psum_ofifo_if.slave bus
);
    localparam int aw = $clog2(depth);
    logic [col-1:0] empty, full;
    logic valid, pop;
    assign valid       = ~|empty;
    assign pop         = bus.rd & valid;
    assign bus.o_valid = valid;
    assign bus.o_full  = |full;
    assign bus.o_ready = ~|full;
    for (genvar g = 0; g < col; g++) begin : lane
        logic [psum_bw-1:0] mem [depth];
        logic [aw:0] wp, rp;
        logic push;
        // full is the pre-edge state, so a same-cycle pop never rescues a write
        assign push     = bus.wr[g] & ~full[g];
        assign empty[g] = wp == rp;
        assign full[g]  = (wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]);
        assign bus.out[g*psum_bw +: psum_bw] = valid ? mem[rp[aw-1:0]] : '0;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= wp + {{aw{1'b0}}, 1'b1};
                if (pop) rp <= rp + {{aw{1'b0}}, 1'b1};
            end
        end
        always_ff @(posedge clk) begin
            if (push) mem[wp[aw-1:0]] <= bus.in[g*psum_bw +: psum_bw];
        end
    end
`ifdef PSUM_OFIFO_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.o_overflow <= 1'b0;
        else if (|(bus.wr & full)) bus.o_overflow <= 1'b1;
    end
`endif
endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Column-parallel output FIFO between the MAC array's bottom row and the per-column sfp accumulate/ReLU stage. Each array column pushes its partial sum independently when it is produced, so columns drain with skew. The block re-aligns them into full rows. It presents a row downstream only when every column has data, and pops all columns together on a read.

## Interface
- `col`, default 8: number of array columns / independent lanes
- `psum_bw`, default 16: partial-sum width per lane, signed
- `depth`, default 64: entries per lane; must be a power of two, minimum 2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset
- `wr`  in  col  per-lane write strobe; bit i pushes lane i
- `in`  in  col*psum_bw  lane i data at bits [i*psum_bw +: psum_bw]
- `rd`  in  1  pops one entry from every lane
- `out`  out  col*psum_bw  head of every lane, same packing as `in`
- `o_valid`  out  1  every lane non-empty; `out` is meaningful
- `o_full`  out  1  at least one lane full
- `o_ready`  out  1  no lane full; equals ~`o_full`
- `o_overflow`  out  1  sticky dropped-write flag; present only with `PSUM_OFIFO_OVF_EN`

## Operation
- Per lane:
  - depth × psum_bw storage
  - write pointer and read pointer, each log2(depth)+1 bits; the extra MSB distinguishes full from empty
  - lane empty: pointers fully equal
  - lane full: MSBs differ and low bits are equal
- Write, lane i:
  - Accepted when `wr[i]` = 1 and lane i was not full at the start of the cycle.
  - Storage at wptr_i low bits ← lane i slice of `in`; wptr_i increments, wrapping modulo 2·depth.
  - A write to a full lane is dropped, even if `rd` pops that lane in the same cycle. Storage and pointers are untouched.
- Read:
  - Accepted when `rd` = 1 and `o_valid` = 1.
  - Every lane's rptr increments, wrapping modulo 2·depth.
  - `rd` while `o_valid` = 0 is ignored; no lane moves.
- Simultaneous accepted write and read on a lane: both take effect. Occupancy is unchanged; data ordering is preserved.
- `out` is first-word fall-through: lane i shows storage[rptr_i], combinational from the pointers. It is forced to all-zero whenever `o_valid` = 0.
- Data passes unmodified; there is no sign handling or arithmetic. The sfp stage downstream accumulates and applies ReLU.
- Flags are combinational from the pointers:
  - `o_valid` = AND over lanes of non-empty
  - `o_full` = OR over lanes of full

## Timing
- Reset (`reset` = 0, asynchronous assert; release synchronous to `clk`):
  - all pointers 0
  - `o_valid` = 0, `out` = 0, `o_full` = 0, `o_ready` = 1, `o_overflow` = 0
  - storage is not reset
- Asserting reset mid-stream discards all contents immediately. No pop or push completes in the cycle reset releases unless sampled on a later edge.
- Write-to-visible latency: 1 cycle. The last lane written at edge N → `o_valid` = 1 after edge N; `out` is valid in the same cycle.
- Read: `rd` sampled at edge N pops. `out` shows the next row after edge N, or zero if any lane becomes empty.
- Sustained throughput: one row per cycle with all `wr` = 1 and `rd` = 1 every cycle.
- Pointer wrap: after 2·depth accepted ops a pointer returns to 0. Full/empty detection must stay correct across the wrap.

## Configuration
- `PSUM_OFIFO_OVF_EN` defined:
  - `o_overflow` port and a sticky register exist.
  - Sets on the edge after any `wr[i]` = 1 while lane i is full.
  - Cleared only by `reset`.
- `PSUM_OFIFO_OVF_EN` undefined:
  - The port and register are absent.
  - Dropped writes are silent; all other behaviour is identical.

## Test plan
- Reset check:
  - Hold `reset` = 0 with `wr` all-ones → `o_valid` = 0, `out` = 0, `o_full` = 0, `o_ready` = 1, `o_overflow` = 0.
  - Release reset → still empty.
- Skewed fill, col=8:
  - Write lane i at cycle i with value 100+i → `o_valid` stays 0 until the cycle after lane 7's write.
  - Then `out` lanes = 100..107.
  - `rd` = 1 for one cycle → `o_valid` = 0, `out` = 0.
- Full / drop, depth=64:
  - 64 writes to lane 0 with values 0..63 → `o_full` = 1, `o_ready` = 0.
  - A 65th write of 999 is dropped; with `PSUM_OFIFO_OVF_EN`, `o_overflow` = 1.
  - Fill the other lanes, then 64 reads → lane 0 returns 0..63, never 999.
- Simultaneous push/pop on a full lane:
  - Lane 0 full, all lanes non-empty; `wr[0]` = 1 with value 7, plus `rd` = 1 → one pop occurs and the write is dropped.
  - Lane 0 occupancy drops to 63; `o_full` deasserts if no other lane is full.
- Wrap-around:
  - Streaming 200 rows with `wr` all-ones and `rd` = 1 each cycle after the first row, data = row index in all lanes.
  - Output sequence 0..199 in order; no spurious `o_full` or `o_valid` glitch across pointer wrap.
- Read on empty and mid-stream reset:
  - `rd` = 1 with lane 3 empty → no lane pointer moves; later data still emerges in order.
  - Assert `reset` = 0 with 10 rows stored → flags return to reset values immediately; subsequent writes start from empty.
